// File: rtl/checksum_pkg.sv
// Shared definitions for the streaming one's-complement checksum engine.
// Holds the FSM state type, the mode encodings and a 16-bit end-around-carry
// adder function that models can reuse. No ports.
package checksum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_VER = 1'b1;

    localparam int unsigned SUM_W = 16;

    // One's-complement add: fold the carry out back into bit 0.
    function automatic logic [SUM_W-1:0] ones_add(input logic [SUM_W-1:0] a,
                                                  input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W-1:0] + {{(SUM_W-1){1'b0}}, s[SUM_W]};
    endfunction

endpackage

// File: rtl/ones_add_w.sv
// Parametrised one's-complement adder with end-around carry.
// Ports:
//   a, b : WIDTH-bit operands
//   sum  : WIDTH-bit one's-complement sum
module ones_add_w #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] s;

    // The folded add cannot carry again: the largest raw sum is 2*(2^W-1).
    always_comb begin
        s   = {1'b0, a} + {1'b0, b};
        sum = s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, s[WIDTH]};
    end

endmodule

// File: rtl/checksum_stream.sv
// Streaming one's-complement checksum engine.
// Words arrive over a valid/ready handshake with a last marker and are
// accumulated with end-around carry; after the final word a single result beat
// is offered. Generate mode yields the checksum, verify mode the residue plus
// a pass flag.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mode                : 0 generate, 1 verify (sampled on first beat)
//   in_valid/in_ready   : input handshake; in_data word, in_last end marker
//   out_valid/out_ready : result handshake
//   out_sum             : ~accumulator; out_ok verify pass; out_len_err truncated
//   out_count           : words in the message
//   err_count           : only with CHECKSUM_STREAM_ERRCNT_EN, saturating count
//                         of failed verifies and truncated messages
module checksum_stream
    import checksum_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_WORDS = 64,
    parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ok,
    output logic             out_len_err,
    output logic [CNT_W-1:0] out_count
`ifdef CHECKSUM_STREAM_ERRCNT_EN
    ,
    output logic [15:0]      err_count
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_sum;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;
    logic             mode_q;
    logic             mode_eff;
    logic             beat;
    logic             trunc;
    logic             finish;
    logic             out_hs;

    logic [WIDTH-1:0] sum_q;
    logic             ok_q;
    logic             len_err_q;
    logic [CNT_W-1:0] cnt_out_q;

    ones_add_w #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (acc_q),
        .b   (in_data),
        .sum (acc_sum)
    );

    assign beat      = in_valid & in_ready;
    assign count_inc = count_q + CNT_W'(1);
    // The first beat of a message uses the live mode, later beats the latched one.
    assign mode_eff  = (count_q == '0) ? mode : mode_q;
    assign trunc     = !in_last && (count_inc == CNT_W'(MAX_WORDS));
    assign finish    = beat && (in_last || trunc);
    assign out_hs    = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (finish) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            count_q   <= '0;
            mode_q    <= MODE_GEN;
            sum_q     <= '0;
            ok_q      <= 1'b0;
            len_err_q <= 1'b0;
            cnt_out_q <= '0;
        end else begin
            state_q <= state_d;
            if (beat) begin
                acc_q   <= acc_sum;
                count_q <= count_inc;
                if (count_q == '0) mode_q <= mode;
            end
            if (finish) begin
                sum_q     <= ~acc_sum;
                ok_q      <= (mode_eff == MODE_VER) && (acc_sum == {WIDTH{1'b1}});
                len_err_q <= trunc;
                cnt_out_q <= count_inc;
            end
            if (out_hs) begin
                acc_q     <= '0;
                count_q   <= '0;
                len_err_q <= 1'b0;
            end
        end
    end

    assign out_sum     = sum_q;
    assign out_ok      = ok_q;
    assign out_len_err = len_err_q;
    assign out_count   = cnt_out_q;

`ifdef CHECKSUM_STREAM_ERRCNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (out_hs && (((mode_q == MODE_VER) && !ok_q) || len_err_q)
                     && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_checksum_stream.sv
module tb_checksum_stream;
    import checksum_pkg::*;

    typedef struct packed {
        logic [15:0] sum;
        logic        ok;
        logic        len_err;
        logic [6:0]  cnt;
        logic        is_err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode      [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] in_data   [2];
    logic        in_last   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [15:0] out_sum   [2];
    logic        out_ok    [2];
    logic        out_len_err [2];
    logic [6:0]  out_count0;
    logic [2:0]  out_count1;
    logic [6:0]  out_count [2];
`ifdef CHECKSUM_STREAM_ERRCNT_EN
    logic [15:0] err_count [2];
`endif

    assign out_count[0] = out_count0;
    assign out_count[1] = {4'd0, out_count1};

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    int unsigned m_acc  [2];
    int          m_cnt  [2];
    logic        m_mode [2];
    int          exp_err[2];

    always #5 clk = ~clk;

    checksum_stream #(.WIDTH(16), .MAX_WORDS(64)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode[0]),
        .in_valid    (in_valid[0]),
        .in_ready    (in_ready[0]),
        .in_data     (in_data[0]),
        .in_last     (in_last[0]),
        .out_valid   (out_valid[0]),
        .out_ready   (out_ready[0]),
        .out_sum     (out_sum[0]),
        .out_ok      (out_ok[0]),
        .out_len_err (out_len_err[0]),
        .out_count   (out_count0)
`ifdef CHECKSUM_STREAM_ERRCNT_EN
        ,
        .err_count   (err_count[0])
`endif
    );

    checksum_stream #(.WIDTH(16), .MAX_WORDS(4)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode[1]),
        .in_valid    (in_valid[1]),
        .in_ready    (in_ready[1]),
        .in_data     (in_data[1]),
        .in_last     (in_last[1]),
        .out_valid   (out_valid[1]),
        .out_ready   (out_ready[1]),
        .out_sum     (out_sum[1]),
        .out_ok      (out_ok[1]),
        .out_len_err (out_len_err[1]),
        .out_count   (out_count1)
`ifdef CHECKSUM_STREAM_ERRCNT_EN
        ,
        .err_count   (err_count[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // Independent model: integer add, then fold any carry back in.
    function automatic logic [15:0] fold_add(input int unsigned a, input logic [15:0] b);
        int unsigned s;
        s = a + 32'(b);
        if (s > 32'h0000FFFF) s = s - 32'h0000FFFF;
        return s[15:0];
    endfunction

    function automatic int max_w(input int d);
        return (d == 0) ? 64 : 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic send(input int d, input logic [15:0] data, input logic last,
                        input logic md);
        int   n;
        exp_t e;
        logic [15:0] res;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_last[d]  = last;
        mode[d]     = md;
        n = 0;
        while (!in_ready[d] && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            check_eq("in_ready_timeout", 32'(in_ready[d]), 32'd1);
            in_valid[d] = 1'b0;
            return;
        end
        tick();
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
        if (m_cnt[d] == 0) m_mode[d] = md;
        m_acc[d] = 32'(fold_add(m_acc[d], data));
        m_cnt[d]++;
        if (last || m_cnt[d] == max_w(d)) begin
            res       = ~m_acc[d][15:0];
            e.sum     = res;
            e.ok      = (m_mode[d] == MODE_VER) && (res == 16'h0000);
            e.len_err = !last;
            e.cnt     = 7'(m_cnt[d]);
            e.is_err  = ((m_mode[d] == MODE_VER) && !e.ok) || !last;
            push_exp(d, e);
            m_acc[d] = 0;
            m_cnt[d] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_last[d]  = 1'b0;
            m_acc[d]    = 0;
            m_cnt[d]    = 0;
            m_mode[d]   = MODE_GEN;
            exp_err[d]  = 0;
        end
        q0.delete();
        q1.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        check_eq("drain_q0", 32'(q0.size()), 32'd0);
        check_eq("drain_q1", 32'(q1.size()), 32'd0);
    endtask

    // Scoreboard: a result is compared on the cycle its handshake completes.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst && out_valid[d] && out_ready[d]) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    check_eq("spurious_out", 32'(out_valid[d]), 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check_eq("sb_sum", 32'(out_sum[d]), 32'(e.sum));
                    check_eq("sb_ok", 32'(out_ok[d]), 32'(e.ok));
                    check_eq("sb_len_err", 32'(out_len_err[d]), 32'(e.len_err));
                    check_eq("sb_count", 32'(out_count[d]), 32'(e.cnt));
`ifdef CHECKSUM_STREAM_ERRCNT_EN
                    check_eq("sb_err_count", 32'(err_count[d]), 32'(exp_err[d]));
                    if (e.is_err) exp_err[d]++;
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hold_sum;
        logic [6:0]  hold_cnt;
        logic [15:0] gen_words [5];
        gen_words = '{16'h00FE, 16'hC523, 16'hFDA1, 16'hD68A, 16'hAF02};
        for (int d = 0; d < 2; d++) begin
            mode[d] = MODE_GEN;
            in_data[d] = '0;
            out_ready[d] = 1'b1;
        end
        @(negedge clk);
        do_reset();

        check_eq("rst_in_ready", 32'(in_ready[0]), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check_eq("rst_out_sum", 32'(out_sum[0]), 32'd0);
        check_eq("rst_out_ok", 32'(out_ok[0]), 32'd0);
        check_eq("rst_len_err", 32'(out_len_err[0]), 32'd0);
        check_eq("rst_out_count", 32'(out_count[0]), 32'd0);
`ifdef CHECKSUM_STREAM_ERRCNT_EN
        check_eq("rst_err_count", 32'(err_count[0]), 32'd0);
`endif

        // Generate
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check_eq("gen_no_early_valid", 32'(out_valid[0]), 32'd0);
            send(0, gen_words[i], (i == 4), MODE_GEN);
        end
        check_eq("gen_valid", 32'(out_valid[0]), 32'd1);
        check_eq("gen_sum", 32'(out_sum[0]), 32'h0000B6AE);
        check_eq("gen_ok", 32'(out_ok[0]), 32'd0);
        check_eq("gen_count", 32'(out_count[0]), 32'd5);

        // Verify, good
        for (int i = 0; i < 5; i++) send(0, gen_words[i], 1'b0, MODE_VER);
        send(0, 16'hB6AE, 1'b1, MODE_VER);
        check_eq("ver_sum", 32'(out_sum[0]), 32'h0);
        check_eq("ver_ok", 32'(out_ok[0]), 32'd1);
        check_eq("ver_count", 32'(out_count[0]), 32'd6);

        // Verify, corrupted
        for (int i = 0; i < 4; i++) send(0, gen_words[i], 1'b0, MODE_VER);
        send(0, 16'hAF03, 1'b0, MODE_VER);
        send(0, 16'hB6AE, 1'b1, MODE_VER);
        check_eq("bad_sum", 32'(out_sum[0]), 32'h0000FFFE);
        check_eq("bad_ok", 32'(out_ok[0]), 32'd0);
        tick();
`ifdef CHECKSUM_STREAM_ERRCNT_EN
        check_eq("bad_err_count", 32'(err_count[0]), 32'd1);
`endif

        // Backpressure in DONE
        out_ready[0] = 1'b0;
        send(0, 16'h1234, 1'b0, MODE_GEN);
        send(0, 16'h5678, 1'b0, MODE_GEN);
        send(0, 16'h9ABC, 1'b1, MODE_GEN);
        check_eq("bp_sum", 32'(out_sum[0]), 32'h0000FC96);
        hold_sum = out_sum[0];
        hold_cnt = out_count[0];
        in_valid[0] = 1'b1;
        in_data[0]  = 16'h0001;
        in_last[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", 32'(out_valid[0]), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready[0]), 32'd0);
            check_eq("bp_sum_stable", 32'(out_sum[0]), 32'(hold_sum));
            check_eq("bp_cnt_stable", 32'(out_count[0]), 32'(hold_cnt));
            tick();
        end
        out_ready[0] = 1'b1;
        check_eq("bp_in_ready_hs", 32'(in_ready[0]), 32'd0);
        tick();
        check_eq("bp_in_ready_after", 32'(in_ready[0]), 32'd1);
        send(0, 16'h0001, 1'b1, MODE_GEN);
        check_eq("bp_next_sum", 32'(out_sum[0]), 32'h0000FFFE);

        // One-word verify message
        send(0, 16'hFFFF, 1'b1, MODE_VER);
        check_eq("one_word_ok", 32'(out_ok[0]), 32'd1);
        check_eq("one_word_cnt", 32'(out_count[0]), 32'd1);

        // Truncation at MAX_WORDS = 4
        for (int i = 1; i <= 4; i++) send(1, 16'(i), 1'b0, MODE_GEN);
        check_eq("trunc_valid", 32'(out_valid[1]), 32'd1);
        check_eq("trunc_len_err", 32'(out_len_err[1]), 32'd1);
        check_eq("trunc_count", 32'(out_count[1]), 32'd4);
        check_eq("trunc_sum", 32'(out_sum[1]), 32'h0000FFF5);
        send(1, 16'h0005, 1'b0, MODE_GEN);
        send(1, 16'h0006, 1'b0, MODE_GEN);
        send(1, 16'h0007, 1'b1, MODE_GEN);
        check_eq("carry_sum", 32'(out_sum[1]), 32'h0000FFED);
        check_eq("carry_count", 32'(out_count[1]), 32'd3);
        check_eq("carry_len_err", 32'(out_len_err[1]), 32'd0);
        // Exactly MAX_WORDS with last is not a truncation
        for (int i = 0; i < 4; i++) send(1, 16'h1111, (i == 3), MODE_GEN);
        check_eq("full_len_err", 32'(out_len_err[1]), 32'd0);
        check_eq("full_sum", 32'(out_sum[1]), 32'h0000BBBB);
        drain();
`ifdef CHECKSUM_STREAM_ERRCNT_EN
        check_eq("trunc_err_count", 32'(err_count[1]), 32'd1);
`endif

        // Reset mid-message
        for (int i = 0; i < 3; i++) send(0, 16'h4000, 1'b0, MODE_GEN);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check_eq("rst_mid_no_valid", 32'(out_valid[0]), 32'd0);
            tick();
        end
        send(0, 16'h0001, 1'b0, MODE_GEN);
        send(0, 16'hFFFE, 1'b1, MODE_GEN);
        check_eq("post_rst_sum", 32'(out_sum[0]), 32'h0);
        check_eq("post_rst_count", 32'(out_count[0]), 32'd2);
        drain();

        // Reset while in DONE
        out_ready[0] = 1'b0;
        send(0, 16'h00AA, 1'b1, MODE_GEN);
        check_eq("done_valid", 32'(out_valid[0]), 32'd1);
        do_reset();
        out_ready[0] = 1'b1;
        check_eq("done_rst_valid", 32'(out_valid[0]), 32'd0);
        check_eq("done_rst_in_ready", 32'(in_ready[0]), 32'd1);
        tick();
        check_eq("done_rst_still_low", 32'(out_valid[0]), 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/checksum_stream.md
# checksum_stream

Streaming one's-complement checksum engine, the sequential successor to the combinational N-word checksum. Words arrive one per cycle over a valid/ready handshake with a `last` marker, and the block accumulates them with end-around carry. After `last` it emits a one-beat result. In generate mode the result is the checksum to append. In verify mode the result is the residue plus a pass/fail flag. It sits between the packet framer and the link layer, one instance per direction.

## Interface
- `WIDTH`, 16: word width in bits, ≥ 8.
- `MAX_WORDS`, 64: maximum words per message, including an appended checksum word in verify mode.
- `CNT_W`, $clog2(MAX_WORDS+1): width of the word counter.

- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mode` input 1: 0 = generate, 1 = verify. Sampled on the first accepted beat of a message.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: block can accept a word.
- `in_data` input WIDTH: input word.
- `in_last` input 1: final word of the message.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_sum` output WIDTH: ~accumulator, i.e. the checksum (generate) or the residue (verify).
- `out_ok` output 1: verify mode only, high when `out_sum == 0`; always 0 in generate mode.
- `out_len_err` output 1: message was truncated at `MAX_WORDS`.
- `out_count` output CNT_W: number of words accumulated in this message.
- `err_count` output 16: present only with `CHECKSUM_STREAM_ERRCNT_EN`.

## Operation
- State machine with two states, `ACCUM` and `DONE`. Reset state is `ACCUM`.
- `ACCUM`:
  - `in_ready = 1`.
  - On each beat (`in_valid & in_ready`): `s = acc + in_data` as WIDTH+1 bits, then `acc <= s[WIDTH-1:0] + s[WIDTH]`. This never overflows again.
  - `count` increments on each beat.
  - `mode` is latched into `mode_q` when `count == 0`.
- Leaving `ACCUM`: on a beat with `in_last`, or on the beat that makes `count == MAX_WORDS` with `in_last = 0`:
  - The state goes to `DONE`.
  - The result registers are loaded from the updated accumulator.
  - `out_len_err` is set in the truncation case.
  - In the truncation case, further words up to the next `in_last` belong to the next message; the block does not drop them.
- `DONE`:
  - `in_ready = 0` and `out_valid = 1`. All outputs are held stable until `out_ready`.
  - On `out_valid & out_ready`: `acc`, `count` and `out_len_err` clear and the state returns to `ACCUM`.
- Generate and verify share the same datapath. A correct message in verify mode, with its checksum appended, accumulates to all-ones, so `out_sum = 0` and `out_ok = 1`.
- `rst` takes effect mid-message or in `DONE` alike: the message is discarded and no result is produced.

## Timing
- Reset values: `in_ready = 1` (in the cycle after `rst` is released), `out_valid = 0`, `out_sum = 0`, `out_ok = 0`, `out_len_err = 0`, `out_count = 0`, `err_count = 0`.
- Latency: `out_valid` rises in the cycle after the `in_last` beat is accepted.
- Throughput: an N-word message takes N + 1 cycles when `out_ready` is held high, giving one bubble per message.
- In `DONE`, `in_ready` is low even while `out_ready = 1`; the next message's first beat can be accepted in the cycle after the output handshake.
- `out_ready` is ignored while `out_valid = 0`.
- `in_valid` may be asserted while `in_ready = 0`. The source must hold the word until it is accepted.
- A 1-word message with `in_last` on its first beat is legal.
- A message with `MAX_WORDS = 1` truncates after every word.

## Configuration
- `CHECKSUM_STREAM_ERRCNT_EN` defined:
  - Port `err_count[15:0]` exists.
  - It increments on each output handshake where the result is in verify mode with `out_ok = 0`, or where `out_len_err = 1`.
  - It saturates at 16'hFFFF and clears only on `rst`.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Package `checksum_pkg` holds:
  - State enum `ACCUM`/`DONE`.
  - Mode constants `MODE_GEN = 0` and `MODE_VER = 1`.
  - Function `ones_add(a, b)` returning the end-around-carry sum, for reuse by bench models.
- One sub-module, `ones_add_w`: the parametrised WIDTH one's-complement adder. The accumulator instantiates it once.

## Test plan
- Generate, words 00FE, C523, FDA1, D68A, AF02 with `in_last` on AF02 → one cycle later `out_valid = 1`, `out_sum = B6AE`, `out_ok = 0`, `out_count = 5`.
- Verify, the same five words plus B6AE → `out_sum = 0000`, `out_ok = 1`, `out_count = 6`.
- Verify with AF02 replaced by AF03 → `out_sum = FFFE`, `out_ok = 0`. With the macro defined, `err_count = 1`.
- Backpressure: hold `out_ready = 0` for 5 cycles in `DONE` → outputs stay stable, `in_ready = 0`, and an offered word is not accepted until the cycle after the handshake.
- `MAX_WORDS = 4`, six words with no `in_last` → result after the 4th word with `out_len_err = 1`. Words 5–6 start the next message.
- Assert `rst` after 3 words of a message → `out_valid` never rises for it. The next message 0001, FFFE(last) in generate mode yields `out_sum = 0000`.
